// File: rtl/mmu_tlb_op_ctrl.sv
// TLB instruction sequencer: waits for the memory system to go quiet, issues one
// MMU command strobe, lets CP0 settle, then requests a refetch of the next PC.
//
// state  | meaning
// IDLE   | waiting for a TLB instruction from the pipeline
// DRAIN  | counting consecutive idle-memory cycles before execution
// EXEC   | one-cycle command strobe to the MMU mapping block
// WB     | one-cycle CP0 settle, no strobes
// FLUSH  | refetch from latched PC + 4, operation retired
module mmu_tlb_op_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  input  logic [31:0] op_pc,
  input  logic        mem_busy,
  input  logic        flush_in,
  output logic        stall,
  output logic        is_tlbp,
  output logic        is_tlbr,
  output logic        is_tlbwi,
  output logic        redirect_ena,
  output logic [31:0] redirect_pc,
  output logic        done,
  output logic [15:0] op_count
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_EXEC,
    S_WB,
    S_FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        type_q, type_d;
  logic [31:0]       pc_q, pc_d;
  logic [15:0]       count_q, count_d;
  logic              tlbp_q, tlbp_d;
  logic              tlbr_q, tlbr_d;
  logic              tlbwi_q, tlbwi_d;
  logic              redirect_ena_q, redirect_ena_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic              done_q, done_d;
  logic              accept;

  assign accept = (state_q == S_IDLE) && op_valid && (op_type != 2'b00) && !flush_in;

  // Outputs are registered: they are computed for the state being entered.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    type_d         = type_q;
    pc_d           = pc_q;
    count_d        = count_q;
    tlbp_d         = 1'b0;
    tlbr_d         = 1'b0;
    tlbwi_d        = 1'b0;
    redirect_ena_d = 1'b0;
    redirect_pc_d  = 32'd0;
    done_d         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          type_d  = op_type;
          pc_d    = op_pc;
          cnt_d   = DRAIN_LOAD;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // An older flushing instruction cancels the op even on its last drain cycle.
        if (flush_in) begin
          state_d = S_IDLE;
        end else if (mem_busy) begin
          cnt_d = DRAIN_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_EXEC;
          tlbp_d  = (type_q == 2'b01);
          tlbr_d  = (type_q == 2'b10);
          tlbwi_d = (type_q == 2'b11);
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        state_d        = S_FLUSH;
        redirect_ena_d = 1'b1;
        redirect_pc_d  = pc_q + 32'd4;
        done_d         = 1'b1;
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        count_d = count_q + 16'd1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      type_q         <= 2'b00;
      pc_q           <= 32'd0;
      count_q        <= 16'd0;
      tlbp_q         <= 1'b0;
      tlbr_q         <= 1'b0;
      tlbwi_q        <= 1'b0;
      redirect_ena_q <= 1'b0;
      redirect_pc_q  <= 32'd0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      type_q         <= type_d;
      pc_q           <= pc_d;
      count_q        <= count_d;
      tlbp_q         <= tlbp_d;
      tlbr_q         <= tlbr_d;
      tlbwi_q        <= tlbwi_d;
      redirect_ena_q <= redirect_ena_d;
      redirect_pc_q  <= redirect_pc_d;
      done_q         <= done_d;
    end
  end

  assign stall        = (state_q != S_IDLE) || accept;
  assign is_tlbp      = tlbp_q;
  assign is_tlbr      = tlbr_q;
  assign is_tlbwi     = tlbwi_q;
  assign redirect_ena = redirect_ena_q;
  assign redirect_pc  = redirect_pc_q;
  assign done         = done_q;
  assign op_count     = count_q;

endmodule

// File: tb/tb_mmu_tlb_op_ctrl.sv
// Bench for mmu_tlb_op_ctrl: directed scenarios plus random traffic, checked by a
// scoreboard fed from a transaction-level model of the drain/execute/retire rules.
module tb_mmu_tlb_op_ctrl;
  localparam int D   = 2;
  localparam int BIG = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst, op_valid, mem_busy, flush_in;
  logic [1:0]  op_type;
  logic [31:0] op_pc;
  logic        stall, is_tlbp, is_tlbr, is_tlbwi, redirect_ena, done;
  logic [31:0] redirect_pc;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  mmu_tlb_op_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type), .op_pc(op_pc),
    .mem_busy(mem_busy), .flush_in(flush_in), .stall(stall), .is_tlbp(is_tlbp),
    .is_tlbr(is_tlbr), .is_tlbwi(is_tlbwi), .redirect_ena(redirect_ena),
    .redirect_pc(redirect_pc), .done(done), .op_count(op_count)
  );

  typedef struct {int cyc; logic [1:0] typ;} strobe_t;
  typedef struct {int cyc; logic [31:0] pc; logic [15:0] cnt;} done_t;
  strobe_t sq[$];
  done_t   dq[$];

  int checks = 0;
  int passes = 0;
  int cyc = -1;
  bit mon_en = 1'b0;
  bit exp_stall = 1'b0;

  // Reference model: an op executes once D+1 consecutive quiet cycles have been seen while draining.
  int          free_c = 0;
  bit          draining = 1'b0;
  int          run = 0;
  logic [1:0]  m_type = 2'b00;
  logic [31:0] m_pc = 32'd0;
  logic [15:0] m_count = 16'd0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
  endtask

  task automatic fail(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
  endtask

  function automatic logic [2:0] onehot(logic [1:0] t);
    case (t)
      2'b01:   return 3'b100;
      2'b10:   return 3'b010;
      2'b11:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model();
    exp_stall = (cyc < free_c) || (op_valid && op_type != 2'b00 && !flush_in);
    if (rst) begin
      while (sq.size() > 0 && sq[$].cyc > cyc) void'(sq.pop_back());
      while (dq.size() > 0 && dq[$].cyc > cyc) void'(dq.pop_back());
      draining = 1'b0;
      free_c   = cyc + 1;
      m_count  = 16'd0;
    end else if (draining) begin
      if (flush_in) begin
        draining = 1'b0;
        free_c   = cyc + 1;
      end else begin
        run = mem_busy ? 0 : run + 1;
        if (run == D + 1) begin
          draining = 1'b0;
          m_count  = m_count + 16'd1;
          sq.push_back('{cyc: cyc + 1, typ: m_type});
          dq.push_back('{cyc: cyc + 3, pc: m_pc + 32'd4, cnt: m_count});
          free_c = cyc + 4;
        end
      end
    end else if (cyc >= free_c && op_valid && op_type != 2'b00 && !flush_in) begin
      draining = 1'b1;
      run      = 0;
      m_type   = op_type;
      m_pc     = op_pc;
      free_c   = BIG;
    end
  endtask

  task automatic step(bit r, bit v, logic [1:0] t, logic [31:0] pc, bit b, bit f);
    @(posedge clk);
    #1;
    rst = r; op_valid = v; op_type = t; op_pc = pc; mem_busy = b; flush_in = f;
    cyc++;
    model();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or a retirement.
  bit          cnt_pend = 1'b0;
  logic [15:0] cnt_exp = 16'd0;
  initial begin
    strobe_t s;
    done_t   d;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        if (cnt_pend) begin
          chk("op_count", {16'd0, op_count}, {16'd0, cnt_exp});
          cnt_pend = 1'b0;
        end
        while (sq.size() > 0 && sq[0].cyc < cyc) begin
          fail("strobe_missing", 32'd0, {30'd0, sq[0].typ});
          void'(sq.pop_front());
        end
        while (dq.size() > 0 && dq[0].cyc < cyc) begin
          fail("done_missing", 32'd0, dq[0].pc);
          void'(dq.pop_front());
        end
        if (is_tlbp || is_tlbr || is_tlbwi) begin
          if (sq.size() == 0) fail("strobe_unexpected", {29'd0, is_tlbp, is_tlbr, is_tlbwi}, 32'd0);
          else begin
            s = sq.pop_front();
            chk("strobe_cycle", cyc, s.cyc);
            chk("strobe_bits", {29'd0, is_tlbp, is_tlbr, is_tlbwi}, {29'd0, onehot(s.typ)});
          end
        end
        if (redirect_ena || done) begin
          if (dq.size() == 0) fail("done_unexpected", redirect_pc, 32'd0);
          else begin
            d = dq.pop_front();
            chk("done_cycle", cyc, d.cyc);
            chk("redirect_pc", redirect_pc, d.pc);
            chk("redirect_done_pair", {30'd0, redirect_ena, done}, 32'd3);
            cnt_pend = 1'b1;
            cnt_exp  = d.cnt;
          end
        end else begin
          chk("redirect_pc_idle", redirect_pc, 32'd0);
        end
      end
    end
  end

  task automatic chk_all_zero(string name);
    chk({name, "_outs"}, {26'd0, is_tlbp, is_tlbr, is_tlbwi, redirect_ena, done, 1'b0}, 32'd0);
    chk({name, "_pc"}, redirect_pc, 32'd0);
    chk({name, "_count"}, {16'd0, op_count}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_type = 2'b00; op_pc = 32'd0; mem_busy = 1'b0; flush_in = 1'b0;
    step(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
    chk_all_zero("reset");

    // TLBWI with a quiet memory system
    step(1'b0, 1'b1, 2'b11, 32'h8000_1000, 1'b0, 1'b0);
    idle(8);

    // TLBP held off by five busy cycles
    step(1'b0, 1'b1, 2'b01, 32'h0040_0020, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b00, 32'd0, 1'b1, 1'b0);
    idle(7);

    // TLBR cancelled by a flush in its second drain cycle
    step(1'b0, 1'b1, 2'b10, 32'h1234_5678, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
    idle(5);

    // TLBR with a flush arriving in EXEC still completes
    step(1'b0, 1'b1, 2'b10, 32'h0000_0100, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
    idle(4);

    // PC wrap and op_count wrap
    force dut.count_q = 16'hFFFF;
    #1 release dut.count_q;
    m_count = 16'hFFFF;
    step(1'b0, 1'b1, 2'b11, 32'hFFFF_FFFC, 1'b0, 1'b0);
    idle(8);

    // Reset during WB
    step(1'b0, 1'b1, 2'b11, 32'h0000_2000, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
    chk_all_zero("rst_in_wb");
    idle(2);

    // op_type 00 is not a request
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, 32'h0000_3000, 1'b0, 1'b0);
    idle(2);

    // Back-to-back TLBWI with op_valid held
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 2'b11, 32'h0000_4000, 1'b0, 1'b0);
    idle(4);
    chk("b2b_count", {16'd0, op_count}, 32'd2);

    // Random traffic
    for (int i = 0; i < 500; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    idle(12);

    chk("strobe_queue_empty", sq.size(), 32'd0);
    chk("done_queue_empty", dq.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
